// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer.
package mc_pkg;

  // Sequencer states; the numeric values are visible on the debug state port.
  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExec   = 4'd6;
  localparam logic [3:0] StAluWb  = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StAddiEx = 4'd9;
  localparam logic [3:0] StAddiWb = 4'd10;
  localparam logic [3:0] StJump   = 4'd11;
  localparam logic [3:0] StTrap   = 4'd12;

  // ALU operation encodings.
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // Opcodes (Instr[31:26]).
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes (Instr[5:0]).
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // PC source select.
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

endpackage

// File: rtl/mc_funct_decode.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported codes.
module mc_funct_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       legal_o
);

  // Table lookup; unsupported functs report AND (all-zero) and legal_o low.
  always_comb begin
    alu_op_o = AluAnd;
    legal_o  = 1'b1;
    case (funct_i)
      FnAdd:   alu_op_o = AluAdd;
      FnSub:   alu_op_o = AluSub;
      FnAnd:   alu_op_o = AluAnd;
      FnOr:    alu_op_o = AluOr;
      FnSlt:   alu_op_o = AluSlt;
      default: legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer with memory handshake, optional timeout,
// illegal-instruction trap and retired-instruction counter.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter bit          EN_BNE      = 1'b1,
  parameter bit          EN_ADDI     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      wait_q, wait_d;
  logic             retire;
  logic             in_req;
  logic             timeout_hit;
  logic [2:0]       funct_op;
  logic             funct_legal;

  mc_funct_decode u_funct_decode (
    .funct_i  (funct),
    .alu_op_o (funct_op),
    .legal_o  (funct_legal)
  );

  assign in_req = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  // Limit reached on the last tolerated wait cycle; a same-cycle mem_ready still wins.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                       (wait_q == 32'(MEM_TIMEOUT - 1));

  // Next-state selection and retire strobe.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready)        state_d = StDecode;
        else if (timeout_hit) state_d = StTrap;
      end
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpBne:      state_d = EN_BNE ? StBranch : StTrap;
          OpAddi:     state_d = EN_ADDI ? StAddiEx : StTrap;
          OpJ:        state_d = StJump;
          default:    state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready)        state_d = StMemWb;
        else if (timeout_hit) state_d = StTrap;
      end
      StMemWr: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StExec:   state_d = funct_legal ? StAluWb : StTrap;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  // Wait counter restarts whenever the sequencer moves; it only counts stalled request cycles.
  always_comb begin
    wait_d    = '0;
    if (in_req && !mem_ready && (state_d == state_q)) wait_d = wait_q + 32'd1;
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  // Datapath controls decoded from the current state; everything defaults low.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PcSrcAlu;
    alu_op     = AluAnd;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    trap       = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = SrcBFour;
        alu_op    = AluAdd;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      StDecode: begin
        alu_src_b = SrcBImmSh2;
        alu_op    = AluAdd;
      end
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        alu_op    = AluAdd;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = funct_op;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = AluSub;
        pc_src    = PcSrcAluOut;
        pc_en     = (opcode == OpBne) ? !zero : zero;
      end
      StAddiWb: reg_write = 1'b1;
      StJump: begin
        pc_src = PcSrcJump;
        pc_en  = 1'b1;
      end
      StTrap:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-plan model checked every cycle plus directed literals.
module tb_mc_control_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9;
  localparam int S_ADDIWB = 10, S_JUMP = 11, S_TRAP = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_ready, zero, rst2_n, mr2;
  logic [5:0]  opcode, funct;

  logic        mem_req, mem_we, iord, ir_write, pc_en, alu_src_a, reg_write, mem_to_reg;
  logic        reg_dst, trap;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        t_mem_req, t_mem_we, t_iord, t_ir_write, t_pc_en, t_alu_src_a, t_reg_write;
  logic        t_mem_to_reg, t_reg_dst, t_trap;
  logic [1:0]  t_pc_src, t_alu_src_b;
  logic [2:0]  t_alu_op;
  logic [3:0]  t_state;
  logic [31:0] t_retired;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .trap(trap), .state(state),
    .retired(retired)
  );

  mc_control_fsm #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mr2), .mem_req(t_mem_req), .mem_we(t_mem_we), .iord(t_iord),
    .ir_write(t_ir_write), .pc_en(t_pc_en), .pc_src(t_pc_src), .alu_op(t_alu_op),
    .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b), .reg_write(t_reg_write),
    .mem_to_reg(t_mem_to_reg), .reg_dst(t_reg_dst), .trap(t_trap), .state(t_state),
    .retired(t_retired)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the current step plus the queue of steps still planned for this instruction.
  int          m_cur = S_FETCH;
  int          plan[$];
  logic [31:0] m_ret = 0;
  bit          m_valid = 1'b0;

  function automatic bit is_req(input int s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cur = S_FETCH;
      plan.delete();
      m_ret = 0;
      m_valid = 1'b1;
    end else if (m_valid && m_cur != S_TRAP && !(is_req(m_cur) && !mem_ready)) begin
      if (m_cur == S_FETCH) begin
        m_cur = S_DECODE;
      end else begin
        if (m_cur == S_DECODE) begin
          plan.delete();
          case (opcode)
            6'b100011: plan = '{S_MEMADR, S_MEMRD, S_MEMWB};
            6'b101011: plan = '{S_MEMADR, S_MEMWR};
            6'b000000: plan = funct_ok(funct) ? '{S_EXEC, S_ALUWB} : '{S_EXEC, S_TRAP};
            6'b000100, 6'b000101: plan = '{S_BRANCH};
            6'b001000: plan = '{S_ADDIEX, S_ADDIWB};
            6'b000010: plan = '{S_JUMP};
            default:   plan = '{S_TRAP};
          endcase
        end
        if (plan.size() == 0) begin
          m_ret++;
          m_cur = S_FETCH;
        end else begin
          m_cur = plan.pop_front();
        end
      end
    end
  end

  // Expected control word for a step: {mem_req,mem_we,iord,ir_write,pc_en,pc_src,alu_op,
  // alu_src_a,alu_src_b,reg_write,mem_to_reg,reg_dst,trap,state}.
  function automatic logic [20:0] exp_vec(input int s, input logic [5:0] op,
                                          input logic [5:0] f, input logic z, input logic mr);
    logic mq, we, io, irw, pce, sa, rw, m2r, rd, tr;
    logic [1:0] ps, sb;
    logic [2:0] ao;
    {mq, we, io, irw, pce, sa, rw, m2r, rd, tr} = '0;
    ps = 2'd0; sb = 2'd0; ao = 3'b000;
    case (s)
      S_FETCH:  begin mq = 1; sb = 2'b01; ao = 3'b010; irw = mr; pce = mr; end
      S_DECODE: begin sb = 2'b11; ao = 3'b010; end
      S_MEMADR, S_ADDIEX: begin sa = 1; sb = 2'b10; ao = 3'b010; end
      S_MEMRD:  begin mq = 1; io = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mq = 1; we = 1; io = 1; end
      S_EXEC: begin
        sa = 1;
        case (f)
          6'b100000: ao = 3'b010;
          6'b100010: ao = 3'b110;
          6'b100101: ao = 3'b001;
          6'b101010: ao = 3'b111;
          default:   ao = 3'b000;
        endcase
      end
      S_ALUWB:  begin rw = 1; rd = 1; end
      S_BRANCH: begin sa = 1; ao = 3'b110; ps = 2'b01; pce = (op == 6'b000101) ? !z : z; end
      S_ADDIWB: rw = 1;
      S_JUMP:   begin ps = 2'b10; pce = 1; end
      S_TRAP:   tr = 1;
      default:  ;
    endcase
    return {mq, we, io, irw, pce, ps, ao, sa, sb, rw, m2r, rd, tr, 4'(s)};
  endfunction

  // Every cycle once reset has been seen: full control word and retire count.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_ctrl", 32'({mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_op, alu_src_a,
                             alu_src_b, reg_write, mem_to_reg, reg_dst, trap, state}),
          32'(exp_vec(m_cur, opcode, funct, zero, mem_ready)));
      chk("model_retired", retired, m_ret);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] rfuncts[4];

  initial begin
    rfuncts = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst_n = 0; rst2_n = 0; mem_ready = 1; mr2 = 0; zero = 0;
    opcode = 6'b000000; funct = 6'b100000;
    cyc(2);
    rst_n = 1; #1;
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_trap", trap, 0);
    chk("rst_mem_req", mem_req, 1);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_ir_write", ir_write, 1);
    // add
    cyc(); #1 chk("add_decode", state, 1);
    cyc(); #1 chk("add_exec", state, 6);
    chk("add_alu_op", alu_op, 3'b010);
    cyc(); #1 chk("add_aluwb", state, 7);
    chk("add_reg_write", reg_write, 1);
    chk("add_reg_dst", reg_dst, 1);
    cyc(); #1 chk("add_retired", retired, 1);
    // lw with two wait cycles in MEMRD
    opcode = 6'b100011;
    cyc(3); mem_ready = 0; #1 chk("lw_memrd0", state, 3);
    chk("lw_iord0", iord, 1);
    cyc(); #1 chk("lw_memrd1", state, 3);
    cyc(); mem_ready = 1; #1 chk("lw_memrd2", state, 3);
    chk("lw_iord2", iord, 1);
    cyc(); #1 chk("lw_memwb", state, 4);
    chk("lw_mem_to_reg", mem_to_reg, 1);
    cyc(); #1 chk("lw_back_fetch", state, 0);
    chk("lw_retired", retired, 2);
    // beq taken, bne not taken (zero=1)
    opcode = 6'b000100; zero = 1;
    cyc(2); #1 chk("beq_state", state, 8);
    chk("beq_pc_en", pc_en, 1);
    chk("beq_pc_src", pc_src, 2'b01);
    cyc(); opcode = 6'b000101;
    cyc(2); #1 chk("bne_pc_en", pc_en, 0);
    cyc(); #1 chk("branch_retired", retired, 4);
    // sw with one wait cycle
    opcode = 6'b101011;
    cyc(3); mem_ready = 0; #1 chk("sw_mem_we", mem_we, 1);
    cyc(); mem_ready = 1;
    cyc(); #1 chk("sw_retired", retired, 5);
    // fetch stall, then addi (mem_ready ignored in ADDIEX)
    mem_ready = 0;
    cyc(3); mem_ready = 1; opcode = 6'b001000; #1 chk("stall_fetch", state, 0);
    cyc(2); mem_ready = 0; #1 chk("addiex", state, 9);
    cyc(); mem_ready = 1;
    cyc(); #1 chk("addi_retired", retired, 6);
    // jump
    opcode = 6'b000010;
    cyc(2); #1 chk("jump_pc_src", pc_src, 2'b10);
    cyc(); #1 chk("jump_retired", retired, 7);
    // bne taken (zero=0)
    opcode = 6'b000101; zero = 0;
    cyc(2); #1 chk("bne_taken", pc_en, 1);
    cyc();
    // remaining R-type functs
    opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      funct = rfuncts[i];
      cyc(4);
    end
    #1 chk("rtype_retired", retired, 12);
    // illegal opcode
    opcode = 6'b111111;
    cyc(2); #1 chk("illop_state", state, 12);
    chk("illop_trap", trap, 1);
    cyc(20); #1 chk("illop_trap_held", trap, 1);
    chk("illop_retired", retired, 12);
    rst_n = 0; cyc(); rst_n = 1; #1;
    chk("rst2_state", state, 0);
    chk("rst2_trap", trap, 0);
    chk("rst2_retired", retired, 0);
    // illegal funct
    opcode = 6'b000000; funct = 6'b000111;
    cyc(3); #1 chk("illfn_state", state, 12);
    chk("illfn_trap", trap, 1);
    // timeout instance: four stalled fetch cycles then trap
    cyc(); rst2_n = 1; mr2 = 0;
    cyc(3); #1 chk("to_wait3", t_state, 0);
    cyc(); #1 chk("to_trapped", t_state, 12);
    chk("to_trap", t_trap, 1);
    rst2_n = 0; cyc(); rst2_n = 1;
    cyc(3); mr2 = 1; #1 chk("to_last_wait", t_state, 0);
    chk("to_ready_pc_en", t_pc_en, 1);
    cyc(); #1 chk("to_decode", t_state, 1);
    chk("to_no_trap", t_trap, 0);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
